mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single memory port between the CPU's two requesters: instruction fetch (IF) and data load/store (D).
- Accepts one request at a time and issues it to memory with a valid/ready handshake.
- Waits for the memory response and routes it back to the requester that owns the transaction.
- A watchdog converts a hung memory transaction into an error response, so the CPU never deadlocks.

Parameters:
- ADDR_W, 32, address width (matches `WORD).
- DATA_W, 32, data width (matches `WORD).
- TIMEOUT, 64, maximum number of WAIT-state cycles before an error response is forced (range 2..255).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req_valid  in  1  fetch request present.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_addr  in  ADDR_W  fetch address.
- if_rsp_valid  out  1  one-cycle fetch response strobe.
- if_rsp_data  out  DATA_W  fetched word.
- if_rsp_err  out  1  fetch timed out.
- d_req_valid  in  1  data request present.
- d_req_ready  out  1  data request accepted this cycle.
- d_addr  in  ADDR_W  data address.
- d_we  in  1  1 = store, 0 = load.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  byte enables.
- d_rsp_valid  out  1  one-cycle data response strobe (loads and stores).
- d_rsp_data  out  DATA_W  load data; 0 for stores.
- d_rsp_err  out  1  data access timed out.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_rsp_valid  in  1  memory response strobe.
- mem_rsp_data  in  DATA_W  memory read data.
- err_count  out  8  number of timeouts, saturating at 255.

Behaviour:
- Reset:
  - All outputs are 0; state = IDLE; last_grant = IF; watchdog counter = 0; err_count = 0.
  - Reset asserted mid-transaction abandons the transaction: no response is produced and any later mem_rsp_valid is ignored.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If either req_valid is high, grant one requester. The grant's req_ready is asserted combinationally in the same cycle (the other requester's ready stays 0).
  - Latch addr/we/wdata/be and owner; go to ISSUE.
  - IF requests are latched with we = 0 and be = all ones.
  - mem_rsp_valid arriving in IDLE is discarded.
- Arbitration:
  - A single request is granted immediately.
  - When both requesters are valid, grant the one that is not last_grant (round-robin). Since last_grant resets to IF, D wins the first contention.
  - last_grant updates on every grant.
- ISSUE:
  - mem_req_valid = 1 and the mem_* outputs are driven from the latched registers; they stay stable until mem_req_ready.
  - mem_req_ready = 1 completes the handshake; go to WAIT with the watchdog cleared.
  - There is no timeout in ISSUE.
- WAIT:
  - The watchdog increments every cycle.
  - On mem_rsp_valid, register the response for the owner in the next cycle: rsp_valid = 1 for exactly 1 cycle, rsp_data = mem_rsp_data (0 for stores), err = 0. Go to IDLE.
  - If the watchdog reaches TIMEOUT with no response, on the next cycle the owner gets rsp_valid = 1, err = 1, data = 0. err_count increments (saturating) and the state goes to IDLE.
  - If mem_rsp_valid arrives in the same cycle the watchdog reaches TIMEOUT, the response wins (no error).
- A new grant may occur in the same cycle a response strobe is driven (back-to-back).
- Minimum latency with memory ready immediately and a 1-cycle response:
  - accept at cycle 0;
  - mem_req_valid at cycle 1;
  - mem_rsp_valid at cycle 2;
  - owner rsp_valid at cycle 3.
- The non-owner's rsp_valid is never asserted.
- Exactly one outstanding memory transaction exists at any time.

Decomposition:
- Package cpu_mem_pkg:
  - enum arb_state_t {IDLE, ISSUE, WAIT};
  - enum req_id_t {REQ_IF, REQ_D};
  - constant ERR_CNT_W = 8.
- One sub-module, rr_arb2: a 2-input round-robin grant with a last_grant register. It takes valid[1:0] and a grant-enable and outputs a one-hot grant. It is used only in IDLE.
- All remaining logic (FSM, latches, watchdog, response registers) lives in mem_port_arbiter.

Test Plan:
- Single fetch:
  - Stimulus: if_addr = 0x100; memory ready immediately; 1-cycle response 0xDEADBEEF.
  - Required: if_req_ready at cycle 0, mem_req_valid at cycle 1, if_rsp_valid at cycle 3 with data 0xDEADBEEF; d_rsp_valid stays 0.
- Contention after reset:
  - Stimulus: IF and D both valid at cycle 0 (D store to 0x200 with wdata 0x55, be = 0xF).
  - Required: D is granted first; mem_we = 1, mem_be = 0xF. IF is granted next; then if both are valid again, D is granted (alternating).
- Backpressure:
  - Stimulus: mem_req_ready held low for 5 cycles.
  - Required: mem_addr/wdata stay stable; no timeout; completes normally after ready rises.
- Timeout:
  - Stimulus: TIMEOUT = 4; D load with no mem_rsp_valid.
  - Required: d_rsp_valid with err = 1 and data 0 on the 5th cycle after entering WAIT; err_count = 1. A late mem_rsp_valid afterwards is ignored.
- Timeout boundary:
  - Stimulus: mem_rsp_valid arrives in the same cycle the watchdog reaches TIMEOUT.
  - Required: normal response, err = 0, err_count unchanged.
- Reset mid-WAIT:
  - Stimulus: assert reset for 1 cycle during WAIT, then mem_rsp_valid arrives.
  - Required: no rsp_valid on either requester; state = IDLE; all outputs 0; next contention grants D.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU memory-port arbiter: FSM states, requester ids and counter width.
package cpu_mem_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
  typedef enum logic {REQ_IF, REQ_D} req_id_t;

  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant (bit 0 = IF, bit 1 = D); combinational one-hot grant, zero when en is low.
// last_grant advances on every grant so the other requester wins the next contention.
module rr_arb2
  import cpu_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant
);

  req_id_t last_grant;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid == 2'b11) begin
        grant = (last_grant == REQ_IF) ? 2'b10 : 2'b01;
      end else begin
        grant = valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= REQ_IF;
    end else if (grant[1]) begin
      last_grant <= REQ_D;
    end else if (grant[0]) begin
      last_grant <= REQ_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters; one outstanding transaction, 3-cycle minimum accept-to-response.
// Requesters are held off (ready low) outside IDLE; the memory request holds stable until mem_req_ready; a watchdog forces an error response.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 if_req_valid,
  output logic                 if_req_ready,
  input  logic [ADDR_W-1:0]    if_addr,
  output logic                 if_rsp_valid,
  output logic [DATA_W-1:0]    if_rsp_data,
  output logic                 if_rsp_err,

  input  logic                 d_req_valid,
  output logic                 d_req_ready,
  input  logic [ADDR_W-1:0]    d_addr,
  input  logic                 d_we,
  input  logic [DATA_W-1:0]    d_wdata,
  input  logic [DATA_W/8-1:0]  d_be,
  output logic                 d_rsp_valid,
  output logic [DATA_W-1:0]    d_rsp_data,
  output logic                 d_rsp_err,

  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_we,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic [DATA_W/8-1:0]  mem_be,
  input  logic                 mem_rsp_valid,
  input  logic [DATA_W-1:0]    mem_rsp_data,

  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  arb_state_t          state_q, state_d;
  req_id_t             owner_q;
  logic [1:0]          grant;
  logic                grant_en;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] be_q;
  logic [7:0]          wd_q;
  logic                timed_out;
  logic [1:0]          rsp_vld_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_err_q;

  // Grant is suppressed during reset so no request is accepted in a cycle that gets discarded.
  assign grant_en = (state_q == IDLE) && !reset;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .valid ({d_req_valid, if_req_valid}),
    .en    (grant_en),
    .grant (grant)
  );

  assign if_req_ready = grant[0];
  assign d_req_ready  = grant[1];
  assign timed_out    = (state_q == WAIT) && !mem_rsp_valid && (wd_q == TO);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) state_d = ISSUE;
      end
      ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid || timed_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetches are always full-word reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= REQ_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (grant != 2'b00) begin
      owner_q <= grant[1] ? REQ_D : REQ_IF;
      addr_q  <= grant[1] ? d_addr : if_addr;
      we_q    <= grant[1] & d_we;
      wdata_q <= grant[1] ? d_wdata : '0;
      be_q    <= grant[1] ? d_be : '1;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

  always_ff @(posedge clk) begin
    if (reset || state_q != WAIT) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 8'd1;
    end
  end

  // A response in the same cycle the watchdog expires takes priority over the timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_vld_q  <= 2'b00;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      err_count  <= '0;
    end else begin
      rsp_vld_q <= 2'b00;
      if (state_q == WAIT && mem_rsp_valid) begin
        rsp_vld_q  <= {owner_q == REQ_D, owner_q == REQ_IF};
        rsp_data_q <= we_q ? '0 : mem_rsp_data;
        rsp_err_q  <= 1'b0;
      end else if (timed_out) begin
        rsp_vld_q  <= {owner_q == REQ_D, owner_q == REQ_IF};
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b1;
        if (err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end

  assign if_rsp_valid = rsp_vld_q[0];
  assign if_rsp_data  = rsp_vld_q[0] ? rsp_data_q : '0;
  assign if_rsp_err   = rsp_vld_q[0] & rsp_err_q;
  assign d_rsp_valid  = rsp_vld_q[1];
  assign d_rsp_data   = rsp_vld_q[1] ? rsp_data_q : '0;
  assign d_rsp_err    = rsp_vld_q[1] & rsp_err_q;

endmodule
